// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC, bus handshake and a one-entry decode buffer
//   clk, reset           : clock, synchronous active-high reset
//   ireq_valid/ireq_addr : instruction bus request (addr word-aligned, stable until iresp_data_ok)
//   iresp_data_ok/_data  : single-cycle bus response pulse and instruction
//   out_valid/pc/instr   : buffered instruction offered to decode, accepted by out_ready
//   redirect_valid/_pc   : execute redirect, target low two bits forced to 0
//   fetch_count          : instructions handed to decode since reset
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_count
);
  typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;
  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [63:0] r_pending_pc, w_pending_nxt;
  logic [63:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_instr, w_instr_nxt;
  logic [63:0] r_fetch_count, w_count_nxt;
  logic [63:0] w_redir;
  assign w_redir     = redirect_pc & ~64'd3;
  assign ireq_valid  = (r_state == REQ || r_state == DISCARD) && !reset;
  assign ireq_addr   = r_pc;
  assign out_valid   = (r_state == HOLD) && !reset;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign fetch_count = r_fetch_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_pending_pc  <= '0;
      r_out_pc      <= '0;
      r_out_instr   <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pending_pc  <= w_pending_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_out_instr   <= w_instr_nxt;
      r_fetch_count <= w_count_nxt;
    end
  end
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending_pc;
    w_out_pc_nxt  = r_out_pc;
    w_instr_nxt   = r_out_instr;
    w_count_nxt   = r_fetch_count;
    case (r_state)
      REQ: begin
        if (redirect_valid && iresp_data_ok) begin
          w_pc_nxt = w_redir;
        end else if (redirect_valid) begin
          // keep ireq_addr stable; the old response is still owed and must be swallowed
          w_pending_nxt = w_redir;
          w_state_nxt   = DISCARD;
        end else if (iresp_data_ok) begin
          w_out_pc_nxt = r_pc;
          w_instr_nxt  = iresp_data;
          w_state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir;
          w_state_nxt = REQ;
        end else if (out_ready) begin
          w_pc_nxt    = r_pc + 64'd4;
          w_count_nxt = r_fetch_count + 64'd1;
          w_state_nxt = REQ;
        end
      end
      DISCARD: begin
        if (iresp_data_ok) begin
          w_pc_nxt    = redirect_valid ? w_redir : r_pending_pc;
          w_state_nxt = REQ;
        end else if (redirect_valid) begin
          w_pending_nxt = w_redir;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  logic        clk = 0;
  logic        reset = 1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 0;
  logic        redirect_valid = 0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] fetch_count;
  typedef struct {logic [63:0] pc; logic [31:0] instr;} exp_t;
  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cnt = 0;
  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] instr, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      settle();
      chk("req_valid", 64'(ireq_valid), 64'd1);
      chk("req_addr", ireq_addr, addr);
      chk("no_out_while_req", 64'(out_valid), 64'd0);
      tick();
    end
    iresp_data_ok = 1;
    iresp_data = instr;
    settle();
    chk("req_addr_at_ok", ireq_addr, addr);
    q.push_back('{addr, instr});
    tick();
    iresp_data_ok = 0;
  endtask
  task automatic accept;
    out_ready = 1;
    settle();
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("req_idle_in_hold", 64'(ireq_valid), 64'd0);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk("out_pc", out_pc, e.pc);
      chk("out_instr", 64'(out_instr), 64'(e.instr));
    end
    tick();
    out_ready = 0;
    exp_cnt++;
    chk("fetch_count", fetch_count, exp_cnt);
  endtask
  task automatic redirect_req(input logic [63:0] tgt);
    redirect_valid = 1;
    redirect_pc = tgt;
  endtask
  initial begin
    settle();
    chk("rst_req_valid", 64'(ireq_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    tick();
    reset = 0;
    settle();
    chk("post_rst_addr", ireq_addr, RPC);
    chk("post_rst_count", fetch_count, 64'd0);
    // free run
    for (int k = 0; k < 3; k++) begin
      do_fetch(RPC + 64'(4 * k), 32'h0000_0013, 3);
      accept();
    end
    chk("count_after_3", fetch_count, 64'd3);
    // decode backpressure
    do_fetch(RPC + 64'hC, 32'h00a0_0093, 1);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_pc", out_pc, RPC + 64'hC);
      chk("bp_out_instr", 64'(out_instr), 64'h00a0_0093);
      chk("bp_req_valid", 64'(ireq_valid), 64'd0);
      chk("bp_count", fetch_count, 64'd3);
      tick();
    end
    accept();
    settle();
    chk("bp_next_addr", ireq_addr, RPC + 64'h10);
    // redirect while request in flight
    tick();
    redirect_req(RPC + 64'h100);
    settle();
    chk("rif_addr0", ireq_addr, RPC + 64'h10);
    tick();
    redirect_valid = 0;
    settle();
    chk("rif_addr1", ireq_addr, RPC + 64'h10);
    chk("rif_valid1", 64'(ireq_valid), 64'd1);
    tick();
    iresp_data_ok = 1;
    iresp_data = 32'hbad0_0bad;
    settle();
    chk("rif_addr2", ireq_addr, RPC + 64'h10);
    tick();
    iresp_data_ok = 0;
    settle();
    chk("rif_no_out", 64'(out_valid), 64'd0);
    chk("rif_new_addr", ireq_addr, RPC + 64'h100);
    // redirect coincident with data_ok in REQ
    redirect_req(RPC + 64'h203);
    iresp_data_ok = 1;
    tick();
    redirect_valid = 0;
    iresp_data_ok = 0;
    settle();
    chk("rreq_no_out", 64'(out_valid), 64'd0);
    chk("rreq_addr", ireq_addr, RPC + 64'h200);
    // redirect beats out_ready in HOLD
    do_fetch(RPC + 64'h200, 32'h0010_0113, 1);
    redirect_req(RPC + 64'h203);
    out_ready = 1;
    settle();
    chk("rhold_out_valid", 64'(out_valid), 64'd1);
    void'(q.pop_front());
    tick();
    redirect_valid = 0;
    out_ready = 0;
    settle();
    chk("rhold_no_out", 64'(out_valid), 64'd0);
    chk("rhold_addr", ireq_addr, RPC + 64'h200);
    chk("rhold_count", fetch_count, exp_cnt);
    // double redirect in DISCARD
    redirect_req(RPC + 64'h40);
    tick();
    redirect_req(RPC + 64'h80);
    tick();
    redirect_valid = 0;
    settle();
    chk("dd_addr_held", ireq_addr, RPC + 64'h200);
    tick();
    iresp_data_ok = 1;
    tick();
    iresp_data_ok = 0;
    settle();
    chk("dd_addr", ireq_addr, RPC + 64'h80);
    chk("dd_no_out", 64'(out_valid), 64'd0);
    // zero-wait fetch and handshake
    do_fetch(RPC + 64'h80, 32'h0020_0193, 0);
    accept();
    // pc wrap
    redirect_req(64'hFFFF_FFFF_FFFF_FFFE);
    iresp_data_ok = 1;
    tick();
    redirect_valid = 0;
    iresp_data_ok = 0;
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0213, 2);
    accept();
    settle();
    chk("wrap_addr", ireq_addr, 64'd0);
    // reset with request outstanding
    tick();
    reset = 1;
    settle();
    chk("rst_mid_req_valid", 64'(ireq_valid), 64'd0);
    tick();
    reset = 0;
    exp_cnt = 0;
    q.delete();
    settle();
    chk("rst_mid_addr", ireq_addr, RPC);
    chk("rst_mid_out", 64'(out_valid), 64'd0);
    chk("rst_mid_count", fetch_count, 64'd0);
    // reset while holding an instruction gates out_valid
    do_fetch(RPC, 32'h0040_0293, 1);
    reset = 1;
    settle();
    chk("rst_hold_out", 64'(out_valid), 64'd0);
    chk("rst_hold_req", 64'(ireq_valid), 64'd0);
    tick();
    reset = 0;
    q.delete();
    settle();
    chk("rst_hold_addr", ireq_addr, RPC);
    chk("rst_hold_valid", 64'(ireq_valid), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
